saida_reg: RTL and testbench

- 4-bit registered add datapath: a 2:1 mux selects entradaB or entradaC, the selection is added to entradaA, and the sum is captured in a 4-bit enable register.
- saida_registrador is the registered sum.
- Sits as the accumulate/output stage of the small datapath, feeding downstream logic one cycle after the operands are presented.

---
 rtl/saida_pkg.sv | 11 +
 rtl/registrador_en.sv | 20 ++
 rtl/saida_reg.sv | 51 +++++
 tb/tb_saida_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/saida_pkg.sv
// Shared constants and types for the saida_reg registered-add datapath.
package saida_pkg;

  localparam int WIDTH = 4;

  localparam logic SEL_B = 1'b0;
  localparam logic SEL_C = 1'b1;

  typedef logic [WIDTH-1:0] word_t;

endpackage : saida_pkg

// File: rtl/registrador_en.sv
// WIDTH-bit register with asynchronous active-low clear and synchronous load enable.
module registrador_en #(
  parameter int WIDTH = saida_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule : registrador_en

// File: rtl/saida_reg.sv
// Registered add stage: selects entradaB/entradaC, adds entradaA, and captures the
// wrapped sum in an enabled register one clock later.
module saida_reg
  import saida_pkg::*;
#(
  parameter int WIDTH = saida_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sel_mux,
  input  logic [WIDTH-1:0] entradaA,
  input  logic [WIDTH-1:0] entradaB,
  input  logic [WIDTH-1:0] entradaC,
  output logic [WIDTH-1:0] saida_registrador
);

  logic [WIDTH-1:0] mux_out;
  logic [WIDTH-1:0] soma;
  logic [WIDTH-1:0] carry;

  // A known select never lets an X on the unselected input reach the sum.
  always_comb begin
    mux_out = entradaB;
    if (sel_mux == SEL_C) begin
      mux_out = entradaC;
    end
  end

  assign carry[0] = 1'b0;

  // Ripple-carry chain; the carry out of the top bit is intentionally not built.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign soma[i] = entradaA[i] ^ mux_out[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (entradaA[i] & mux_out[i]) |
                          (carry[i] & (entradaA[i] ^ mux_out[i]));
    end
  end

  registrador_en #(
    .WIDTH (WIDTH)
  ) u_registrador (
    .clk    (clk),
    .rst_n  (rst),
    .enable (enable),
    .d      (soma),
    .q      (saida_registrador)
  );

endmodule : saida_reg

// File: tb/tb_saida_reg.sv
// Directed self-checking bench for saida_reg.
module tb_saida_reg;
  import saida_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  enable;
  logic  sel_mux;
  word_t entradaA;
  word_t entradaB;
  word_t entradaC;
  word_t saida_registrador;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  saida_reg #(.WIDTH(WIDTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .sel_mux           (sel_mux),
    .entradaA          (entradaA),
    .entradaB          (entradaB),
    .entradaC          (entradaC),
    .saida_registrador (saida_registrador)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; sel_mux = 1'b1;
    entradaA = 4'h1; entradaB = 4'h4; entradaC = 4'h4;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (saida_registrador !== 4'h0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", saida_registrador, 4'h0);
    end
    step();
    checks++;
    if (saida_registrador !== 4'h0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", saida_registrador, 4'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++;
    if (saida_registrador !== 4'h0) begin
      failures++;
      $display("FAIL reset_release_en0 got=%h exp=%h", saida_registrador, 4'h0);
    end
  endtask

  task automatic test_add_c();
    word_t a_vals [3] = '{4'h5, 4'h3, 4'h1};
    word_t exp_vals [3] = '{4'h7, 4'h5, 4'h3};
    @(negedge clk);
    enable = 1'b1; sel_mux = 1'b1; entradaC = 4'h2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      entradaA = a_vals[i];
      #1;
      if (i > 0) begin
        checks++;
        if (saida_registrador !== exp_vals[i-1]) begin
          failures++;
          $display("FAIL add_c_no_comb_path[%0d] got=%h exp=%h", i, saida_registrador, exp_vals[i-1]);
        end
      end
      step();
      checks++;
      if (saida_registrador !== exp_vals[i]) begin
        failures++;
        $display("FAIL add_c[%0d] got=%h exp=%h", i, saida_registrador, exp_vals[i]);
      end
    end
  endtask

  task automatic test_select();
    @(negedge clk);
    enable = 1'b1; sel_mux = 1'b1; entradaA = 4'h5; entradaC = 4'h8; entradaB = 4'h4;
    step();
    checks++;
    if (saida_registrador !== 4'hD) begin
      failures++;
      $display("FAIL select_c got=%h exp=%h", saida_registrador, 4'hD);
    end
    @(negedge clk);
    sel_mux = 1'b0;
    step();
    checks++;
    if (saida_registrador !== 4'h9) begin
      failures++;
      $display("FAIL select_b got=%h exp=%h", saida_registrador, 4'h9);
    end
  endtask

  task automatic test_enable_hold();
    @(negedge clk);
    enable = 1'b0; entradaA = 4'h1; entradaC = 4'h8; sel_mux = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (saida_registrador !== 4'h9) begin
        failures++;
        $display("FAIL enable_hold[%0d] got=%h exp=%h", i, saida_registrador, 4'h9);
      end
    end
    @(negedge clk);
    enable = 1'b1;
    step();
    checks++;
    if (saida_registrador !== 4'h9) begin
      failures++;
      $display("FAIL enable_resume got=%h exp=%h", saida_registrador, 4'h9);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    enable = 1'b1; sel_mux = 1'b0; entradaA = 4'hF; entradaB = 4'h1;
    step();
    checks++;
    if (saida_registrador !== 4'h0) begin
      failures++;
      $display("FAIL wrap_f_plus_1 got=%h exp=%h", saida_registrador, 4'h0);
    end
    @(negedge clk);
    entradaA = 4'hA; entradaB = 4'h7;
    step();
    checks++;
    if (saida_registrador !== 4'h1) begin
      failures++;
      $display("FAIL wrap_a_plus_7 got=%h exp=%h", saida_registrador, 4'h1);
    end
  endtask

  task automatic test_unselected_x();
    @(negedge clk);
    enable = 1'b1; sel_mux = 1'b0; entradaA = 4'h1; entradaB = 4'h2; entradaC = 4'bxxxx;
    step();
    checks++;
    if (saida_registrador !== 4'h3) begin
      failures++;
      $display("FAIL unselected_x got=%h exp=%h", saida_registrador, 4'h3);
    end
    entradaC = 4'h0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    enable = 1'b1; sel_mux = 1'b0; entradaA = 4'h6; entradaB = 4'h7;
    step();
    checks++;
    if (saida_registrador !== 4'hD) begin
      failures++;
      $display("FAIL reset_mid_preload got=%h exp=%h", saida_registrador, 4'hD);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (saida_registrador !== 4'h0) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=%h", saida_registrador, 4'h0);
    end
    step();
    checks++;
    if (saida_registrador !== 4'h0) begin
      failures++;
      $display("FAIL reset_mid_hold got=%h exp=%h", saida_registrador, 4'h0);
    end
    @(negedge clk);
    rst = 1'b1; entradaA = 4'h2; entradaB = 4'h3;
    step();
    checks++;
    if (saida_registrador !== 4'h5) begin
      failures++;
      $display("FAIL reset_mid_reload got=%h exp=%h", saida_registrador, 4'h5);
    end
  endtask

  initial begin
    test_reset();
    test_add_c();
    test_select();
    test_enable_hold();
    test_wrap();
    test_unselected_x();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_saida_reg
